// File: rtl/coin_return_dispenser_pkg.sv
// Shared vending-machine constants: arithmetic width, denomination count and coin values.
package coin_return_dispenser_pkg;

  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;
  localparam int kCoin0Val  = 100;
  localparam int kCoin1Val  = 500;
  localparam int kCoin2Val  = 1000;

endpackage

// File: rtl/coin_return_dispenser_coin_select.sv
// Greedy denomination picker: largest coin value that fits the balance and whose hopper is stocked.
module coin_select #(
  parameter int kTotalBits = coin_return_dispenser_pkg::kTotalBits,
  parameter int kNumCoins  = coin_return_dispenser_pkg::kNumCoins,
  parameter int COIN0_VAL  = coin_return_dispenser_pkg::kCoin0Val,
  parameter int COIN1_VAL  = coin_return_dispenser_pkg::kCoin1Val,
  parameter int COIN2_VAL  = coin_return_dispenser_pkg::kCoin2Val
) (
  input  logic [kTotalBits-1:0] remaining,
  input  logic [kNumCoins-1:0]  i_hopper_empty,
  output logic                  found,
  output logic [kNumCoins-1:0]  coin,
  output logic [kTotalBits-1:0] coin_value
);

  logic [kTotalBits-1:0] coin_vals [kNumCoins];

  assign coin_vals[0] = kTotalBits'(COIN0_VAL);
  assign coin_vals[1] = kTotalBits'(COIN1_VAL);
  assign coin_vals[2] = kTotalBits'(COIN2_VAL);

  // Scan every denomination and keep the largest eligible value, so index order does not matter.
  always_comb begin
    found      = 1'b0;
    coin       = '0;
    coin_value = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (!i_hopper_empty[k] && (coin_vals[k] <= remaining) &&
          (!found || (coin_vals[k] > coin_value))) begin
        found      = 1'b1;
        coin       = '0;
        coin[k]    = 1'b1;
        coin_value = coin_vals[k];
      end
    end
  end

endmodule

// File: rtl/coin_return_dispenser.sv
// Change-return sequencer: latches the balance, issues coins one at a time to the hopper, reports leftover.
module coin_return_dispenser #(
  parameter int kTotalBits = coin_return_dispenser_pkg::kTotalBits,
  parameter int COIN0_VAL  = coin_return_dispenser_pkg::kCoin0Val,
  parameter int COIN1_VAL  = coin_return_dispenser_pkg::kCoin1Val,
  parameter int COIN2_VAL  = coin_return_dispenser_pkg::kCoin2Val,
  parameter int kNumCoins  = coin_return_dispenser_pkg::kNumCoins
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_trigger,
  input  logic [kTotalBits-1:0] i_total,
  input  logic [kNumCoins-1:0]  i_hopper_empty,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [kNumCoins-1:0]  o_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_remainder
);

  import coin_return_dispenser_pkg::*;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [kTotalBits-1:0] remaining, remaining_nxt;
  logic [kTotalBits-1:0] coin_val_q, coin_val_nxt;
  logic [kNumCoins-1:0]  coin_nxt;
  logic                  coin_valid_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic [kTotalBits-1:0] remainder_nxt;

  logic                  sel_found;
  logic [kNumCoins-1:0]  sel_coin;
  logic [kTotalBits-1:0] sel_value;

  coin_select #(
    .kTotalBits (kTotalBits),
    .kNumCoins  (kNumCoins),
    .COIN0_VAL  (COIN0_VAL),
    .COIN1_VAL  (COIN1_VAL),
    .COIN2_VAL  (COIN2_VAL)
  ) u_coin_select (
    .remaining      (remaining),
    .i_hopper_empty (i_hopper_empty),
    .found          (sel_found),
    .coin           (sel_coin),
    .coin_value     (sel_value)
  );

  always_comb begin
    state_nxt      = state;
    remaining_nxt  = remaining;
    coin_val_nxt   = coin_val_q;
    coin_nxt       = o_coin;
    coin_valid_nxt = o_coin_valid;
    done_nxt       = 1'b0;
    remainder_nxt  = o_remainder;

    case (state)
      IDLE: begin
        if (i_trigger) begin
          remaining_nxt = i_total;
          state_nxt     = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          coin_nxt       = sel_coin;
          coin_valid_nxt = 1'b1;
          coin_val_nxt   = sel_value;
          state_nxt      = DISPENSE;
        end else begin
          remainder_nxt = remaining;
          state_nxt     = DONE;
        end
      end
      DISPENSE: begin
        // Selection guaranteed coin_val_q <= remaining, so this cannot wrap.
        if (i_coin_ready) begin
          remaining_nxt  = remaining - coin_val_q;
          coin_nxt       = '0;
          coin_valid_nxt = 1'b0;
          state_nxt      = SELECT;
        end
      end
      DONE: begin
        // First DONE cycle raises the pulse; the second drops it and returns to IDLE.
        if (!o_done) begin
          done_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      remaining    <= '0;
      coin_val_q   <= '0;
      o_coin       <= '0;
      o_coin_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_remainder  <= '0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      coin_val_q   <= coin_val_nxt;
      o_coin       <= coin_nxt;
      o_coin_valid <= coin_valid_nxt;
      o_busy       <= busy_nxt;
      o_done       <= done_nxt;
      o_remainder  <= remainder_nxt;
    end
  end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed test-plan cases plus randomized returns against a greedy model.
module tb_coin_return_dispenser;

  logic        clk;
  logic        reset_n;
  logic        i_trigger;
  logic [30:0] i_total;
  logic [2:0]  i_hopper_empty;
  logic        i_coin_ready;
  logic        o_coin_valid;
  logic [2:0]  o_coin;
  logic        o_busy;
  logic        o_done;
  logic [30:0] o_remainder;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  coin_return_dispenser dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_trigger      (i_trigger),
    .i_total        (i_total),
    .i_hopper_empty (i_hopper_empty),
    .i_coin_ready   (i_coin_ready),
    .o_coin_valid   (o_coin_valid),
    .o_coin         (o_coin),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_remainder    (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy change by division: all 1000s, then 500s, then 100s, skipping empty hoppers.
  function automatic int model(input int total, input logic [2:0] empty);
    int vals[3];
    int rem;
    int cnt;
    vals[0] = 100;
    vals[1] = 500;
    vals[2] = 1000;
    rem = total;
    exp_q.delete();
    for (int k = 2; k >= 0; k--) begin
      if (!empty[k]) begin
        cnt = rem / vals[k];
        rem = rem % vals[k];
        for (int j = 0; j < cnt; j++) exp_q.push_back(k);
      end
    end
    return rem;
  endfunction

  task automatic run(input int total, input logic [2:0] empty, input int pct,
                     input int fixed_stalls, input bit pulse);
    int   exp_rem;
    int   cycles;
    int   stalls;
    int   got_n;
    int   fixed_left;
    bit   done_seen;
    bit   stalled;
    bit   pulsed;
    logic [2:0] held;
    exp_rem    = model(total, empty);
    fixed_left = fixed_stalls;
    chk("idle_before_trigger", o_busy, 0);
    i_total        = total;
    i_hopper_empty = empty;
    i_trigger      = 1'b1;
    tick();
    i_trigger = 1'b0;
    i_total   = $urandom_range(9999);
    chk("busy_after_trigger", o_busy, 1);
    cycles = 0; stalls = 0; got_n = 0; done_seen = 0; pulsed = 0; held = '0;
    while (!done_seen && cycles < 400) begin
      stalled = 0;
      if (o_coin_valid) begin
        if (fixed_left > 0) begin
          i_coin_ready = 1'b0;
          fixed_left--;
        end else begin
          i_coin_ready = ($urandom_range(99) >= pct);
        end
        if (i_coin_ready) begin
          if (got_n < exp_q.size()) chk("coin", o_coin, 3'b001 << exp_q[got_n]);
          got_n++;
        end else begin
          stalled = 1;
          stalls++;
          held = o_coin;
          if (pulse && !pulsed) begin
            i_trigger = 1'b1;
            i_total   = 5000;
            pulsed    = 1;
          end
        end
      end else begin
        i_coin_ready = 1'($urandom_range(1));
        chk("coin_zero_when_invalid", o_coin, 0);
      end
      tick();
      cycles++;
      i_trigger = 1'b0;
      if (stalled) begin
        chk("stall_coin_hold", o_coin, held);
        chk("stall_valid_hold", o_coin_valid, 1);
      end
      if (o_done) done_seen = 1;
    end
    chk("done_seen", done_seen, 1);
    chk("coin_count", got_n, exp_q.size());
    chk("latency", cycles, 2 * exp_q.size() + 2 + stalls);
    chk("remainder", o_remainder, exp_rem);
    chk("busy_during_done", o_busy, 1);
    tick();
    chk("done_one_cycle", o_done, 0);
    chk("busy_dropped", o_busy, 0);
    chk("remainder_held", o_remainder, exp_rem);
    if (pulse) begin
      tick();
      chk("stall_trigger_ignored", o_busy, 0);
    end
    i_coin_ready = 1'b0;
    if (!done_seen) begin
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    i_trigger      = 1'b0;
    i_total        = '0;
    i_hopper_empty = '0;
    i_coin_ready   = 1'b0;
    tick();
    tick();
    chk("rst_coin_valid", o_coin_valid, 0);
    chk("rst_coin", o_coin, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_remainder", o_remainder, 0);
    reset_n = 1'b1;
    tick();

    run(1600, 3'b000, 0, 0, 0);
    run(1650, 3'b000, 0, 0, 0);
    run(2000, 3'b100, 0, 0, 0);
    run(500,  3'b000, 0, 3, 1);
    run(0,    3'b000, 0, 0, 0);
    run(350,  3'b001, 0, 0, 0);

    // Reset while a coin is being presented.
    i_total        = 1600;
    i_hopper_empty = 3'b000;
    i_trigger      = 1'b1;
    tick();
    i_trigger = 1'b0;
    tick();
    chk("mid_valid_before_reset", o_coin_valid, 1);
    chk("mid_coin_before_reset", o_coin, 3'b100);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", o_coin_valid, 0);
    chk("mid_rst_coin", o_coin, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    reset_n      = 1'b1;
    i_coin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_done", o_done, 0);
      chk("post_rst_idle", o_busy, 0);
    end
    i_coin_ready = 1'b0;
    run(1600, 3'b000, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      run($urandom_range(120) * 50, 3'($urandom_range(7)), $urandom_range(50), 0, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
